// File: rtl/lottery_pkg.sv
// Shared types and constants for the lottery draw block.
// Contents:
//   state_e           draw FSM states (idle, drawing, draw held)
//   LFSR_TAPS         Galois tap mask for x^16+x^14+x^13+x^11+1
//   DEFAULT_SEED      LFSR reset value and zero-seed substitute
//   DEFAULT_DIGIT_MAX largest accepted digit
//   NUM_DIGITS        digits per draw
//   lfsr_step()       one right-shift Galois step
package lottery_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StDone
    } state_e;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED      = 16'hACE1;
    localparam int unsigned DEFAULT_DIGIT_MAX = 9;
    localparam int unsigned NUM_DIGITS        = 4;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        logic [15:0] nxt;
        nxt = q >> 1;
        if (q[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// Free-running 16-bit Galois LFSR with synchronous seed load.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset, loads SEED
//   load      replace this cycle's step with load_val
//   load_val  new seed; zero is replaced by SEED so the register never locks up
//   q         current LFSR value
module lfsr16_galois
    import lottery_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);

    logic [15:0] lfsr_d;
    logic [15:0] lfsr_q;

    always_comb begin
        if (load) begin
            lfsr_d = (load_val == 16'h0000) ? SEED : load_val;
        end else begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/sorteio_loteria.sv
// Lottery draw: produces four BCD winning digits from an LFSR by rejection
// sampling and presents them through a req/valid/ack handshake.
// Optional build macro: SORTEIO_NO_REPEAT_EN -- when defined, a candidate equal
// to a digit already accepted in the current draw is rejected (digits distinct).
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   draw_req   start a new draw (honoured in idle and when a draw is held)
//   draw_ack   consumer has taken d0..d3 (honoured only when a draw is held)
//   seed_load  load seed_in into the LFSR this cycle
//   seed_in    new LFSR seed (zero maps to SEED)
//   busy       draw in progress
//   valid      d0..d3 hold a completed draw
//   d0..d3     drawn digits, d0 first
//   draw_cnt   completed draws since reset, wraps at 256
module sorteio_loteria
    import lottery_pkg::*;
#(
    parameter logic [15:0] SEED      = DEFAULT_SEED,
    parameter int unsigned DIGIT_MAX = DEFAULT_DIGIT_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw_req,
    input  logic        draw_ack,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic        busy,
    output logic        valid,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [7:0]  draw_cnt
);

    state_e      state_d, state_q;
    logic [1:0]  idx_d, idx_q;
    logic        busy_d, busy_q;
    logic        valid_d, valid_q;
    logic [7:0]  cnt_d, cnt_q;
    logic [3:0]  digits_q [NUM_DIGITS];
    logic        wr_en;

    logic [15:0] lfsr;
    logic [3:0]  cand;
    logic        in_range;
    logic        is_repeat;
    logic        accept;
    logic        unused_lfsr;

    lfsr16_galois #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed_in),
        .q        (lfsr)
    );

    // Candidate is the pre-step value, so a seed load this cycle does not disturb it.
    assign cand        = lfsr[3:0];
    assign unused_lfsr = ^lfsr[15:4];
    assign in_range    = (32'(cand) <= DIGIT_MAX);

`ifdef SORTEIO_NO_REPEAT_EN
    // Only slots below idx_q belong to the current draw; higher ones are stale.
    always_comb begin
        is_repeat = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((2'(i) < idx_q) && (digits_q[i] == cand)) begin
                is_repeat = 1'b1;
            end
        end
    end
`else
    assign is_repeat = 1'b0;
`endif

    assign accept = in_range && !is_repeat;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (draw_req) begin
                    state_d = StDraw;
                    idx_d   = 2'd0;
                    busy_d  = 1'b1;
                end
            end
            StDraw: begin
                if (accept) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'(NUM_DIGITS - 1)) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            end
            StDone: begin
                // A new request takes priority over a simultaneous acknowledge.
                if (draw_req) begin
                    state_d = StDraw;
                    idx_d   = 2'd0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end else if (draw_ack) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_q[i] <= 4'd0;
            end
        end else if (wr_en) begin
            digits_q[idx_q] <= cand;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign d0       = digits_q[0];
    assign d1       = digits_q[1];
    assign d2       = digits_q[2];
    assign d3       = digits_q[3];
    assign draw_cnt = cnt_q;

endmodule

// File: tb/tb_sorteio_loteria.sv
// Self-checking bench for sorteio_loteria: directed scenarios plus randomized
// draws compared against a behavioural draw model.
module tb_sorteio_loteria;

    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          DIGIT_MAX = 9;
`ifdef SORTEIO_NO_REPEAT_EN
    localparam bit NO_REPEAT = 1'b1;
`else
    localparam bit NO_REPEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        draw_req = 1'b0;
    logic        draw_ack = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        busy;
    logic        valid;
    logic [3:0]  d0, d1, d2, d3;
    logic [7:0]  draw_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;
    logic [7:0]  exp_cnt = 8'd0;
    logic [15:0] last_digs = 16'h0000;
    int          repeat_draws = 0;

    always #5 clk = ~clk;

    sorteio_loteria dut (
        .clk       (clk),
        .reset     (reset),
        .draw_req  (draw_req),
        .draw_ack  (draw_ack),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .busy      (busy),
        .valid     (valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .draw_cnt  (draw_cnt)
    );

    // x^16+x^14+x^13+x^11+1, right-shifting Galois form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference LFSR value, following the seed/step rules each clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= SEED;
        else if (seed_load) m_lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
        else m_lfsr <= lfsr_next(m_lfsr);
    end

    // Draw from a start value: returns the packed digits {d3,d2,d1,d0} and the
    // number of draw cycles needed to accept four of them.
    function automatic void model_draw(input logic [15:0] l0, output logic [15:0] digs,
                                       output int k);
        logic [15:0] l;
        logic [3:0]  c;
        int          n;
        bit          ok;
        l = l0;
        n = 0;
        k = 0;
        digs = 16'h0000;
        while (n < 4 && k < 100000) begin
            c = l[3:0];
            ok = (int'(c) <= DIGIT_MAX);
            if (NO_REPEAT) begin
                for (int j = 0; j < n; j++) begin
                    if (digs[4*j +: 4] == c) ok = 1'b0;
                end
            end
            if (ok) begin
                digs[4*n +: 4] = c;
                n++;
            end
            l = lfsr_next(l);
            k++;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_seed(input logic [15:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed_in   = s;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic run_draw(input bit with_ack, input bit spam, input string tag);
        logic [15:0] exp_digs;
        logic [15:0] got_digs;
        int          exp_k;
        int          cyc;
        @(negedge clk);
        draw_req = 1'b1;
        draw_ack = with_ack;
        @(negedge clk);
        draw_req = 1'b0;
        draw_ack = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_valid_start"}, 32'(valid), 32'd0);
        model_draw(m_lfsr, exp_digs, exp_k);
        cyc = 0;
        while (!valid && cyc < 2000) begin
            if (spam) draw_req = (cyc % 2 == 0);
            @(negedge clk);
            cyc++;
        end
        draw_req = 1'b0;
        exp_cnt  = exp_cnt + 8'd1;
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_k));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        got_digs = {d3, d2, d1, d0};
        check({tag, "_digits"}, 32'(got_digs), 32'(exp_digs));
        check({tag, "_cnt"}, 32'(draw_cnt), 32'(exp_cnt));
        last_digs = got_digs;
        // Held one more cycle: no second draw was launched.
        @(negedge clk);
        check({tag, "_hold_valid"}, 32'(valid), 32'd1);
        check({tag, "_hold_busy"}, 32'(busy), 32'd0);
        check({tag, "_hold_cnt"}, 32'(draw_cnt), 32'(exp_cnt));
    endtask

    task automatic ack_draw();
        @(negedge clk);
        draw_ack = 1'b1;
        @(negedge clk);
        draw_ack = 1'b0;
        check("ack_valid", 32'(valid), 32'd0);
        check("ack_busy", 32'(busy), 32'd0);
        check("ack_stale", 32'({d3, d2, d1, d0}), 32'(last_digs));
    endtask

    initial begin
        logic [15:0] s;
        logic [3:0]  dg [4];
        bit          distinct;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_digits", 32'({d3, d2, d1, d0}), 32'd0);
        check("rst_cnt", 32'(draw_cnt), 32'd0);
        reset = 1'b1;

        // Known seed, plain draw, then acknowledge.
        load_seed(16'h1234);
        run_draw(1'b0, 1'b0, "seed1234");
        ack_draw();

        // Zero seed must behave like the default seed.
        load_seed(16'h0000);
        run_draw(1'b0, 1'b0, "seed0");
        ack_draw();

        // Requests during a draw are ignored.
        run_draw(1'b0, 1'b1, "spam");

        // Request plus acknowledge while held: request wins.
        run_draw(1'b1, 1'b0, "req_ack");

        // Reset in the middle of a draw.
        @(negedge clk);
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_digits", 32'({d3, d2, d1, d0}), 32'd0);
        check("arst_cnt", 32'(draw_cnt), 32'd0);
        exp_cnt = 8'd0;
        @(negedge clk);
        reset = 1'b1;

        // Random seeds and handshakes; covers the 255 -> 0 counter wrap.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
                load_seed(s);
            end
            run_draw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
            dg[0] = d0;
            dg[1] = d1;
            dg[2] = d2;
            dg[3] = d3;
            distinct = 1'b1;
            for (int a = 0; a < 4; a++) begin
                check("rnd_range", 32'(int'(dg[a]) <= DIGIT_MAX), 32'd1);
                for (int b = a + 1; b < 4; b++) begin
                    if (dg[a] == dg[b]) distinct = 1'b0;
                end
            end
`ifdef SORTEIO_NO_REPEAT_EN
            check("rnd_distinct", 32'(distinct), 32'd1);
`else
            if (!distinct) repeat_draws++;
`endif
            if ($urandom_range(0, 3) == 0) ack_draw();
        end
`ifndef SORTEIO_NO_REPEAT_EN
        check("repeat_seen", 32'(repeat_draws > 0), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
